enum_tag_fifo: RTL and testbench



---
 rtl/enum_tag_pkg.sv | 14 +
 rtl/tag_match_vec.sv | 20 ++
 rtl/enum_tag_fifo.sv | 86 ++++++++
 tb/tb_enum_tag_fifo.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/enum_tag_pkg.sv
// Shared tag type and pointer-wrap helper for the tag queue.
package enum_tag_pkg;

  typedef enum logic [1:0] {TAG_0, TAG_1, TAG_2, TAG_3} tag_t;

  localparam int unsigned PTR_MAX_W = 6;

  // Wraps from depth-1 back to zero, so any depth (not only 2^n) works.
  function automatic logic [PTR_MAX_W-1:0] next_ptr(input logic [PTR_MAX_W-1:0] ptr,
                                                    input int unsigned depth);
    return (32'(ptr) == depth - 1) ? '0 : ptr + 6'd1;
  endfunction

endpackage

// File: rtl/tag_match_vec.sv
// Membership lookup: hit when any valid entry holds query_tag.
module tag_match_vec
  import enum_tag_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  tag_t             tags [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  tag_t             query_tag,
  output logic             query_hit
);

  always_comb begin
    query_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tags[i] == query_tag)) query_hit = 1'b1;
    end
  end

endmodule

// File: rtl/enum_tag_fifo.sv
// First-word fall-through queue of enumerated tags with a combinational
// membership query over the registered entries.
module enum_tag_fifo
  import enum_tag_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  tag_t             push_tag,
  output logic             pop_valid,
  input  logic             pop_ready,
  output tag_t             pop_tag,
  input  tag_t             query_tag,
  output logic             query_hit,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  tag_t             mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_fire;
  logic             pop_fire;

  // Status flags depend only on the registered count.
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign count      = count_q;
  assign pop_tag    = empty ? TAG_0 : mem[rd_ptr];

  assign push_fire = push_valid && !full;
  assign pop_fire  = pop_ready && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      valid   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_fire) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= PTR_W'(next_ptr(PTR_MAX_W'(wr_ptr), DEPTH));
      end
      if (pop_fire) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= PTR_W'(next_ptr(PTR_MAX_W'(rd_ptr), DEPTH));
      end
      case ({push_fire, pop_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage is not reset; the valid bits qualify every read.
  always_ff @(posedge clk) begin
    if (push_fire && !flush) mem[wr_ptr] <= push_tag;
  end

  tag_match_vec #(.DEPTH(DEPTH)) u_match (
    .tags      (mem),
    .valid     (valid),
    .query_tag (query_tag),
    .query_hit (query_hit)
  );

endmodule

// File: tb/tb_enum_tag_fifo.sv
// Directed scoreboard bench for enum_tag_fifo at DEPTH=5.
module tb_enum_tag_fifo;
  import enum_tag_pkg::*;

  localparam int unsigned DEPTH = 5;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             push_valid;
  logic             push_ready;
  tag_t             push_tag;
  logic             pop_valid;
  logic             pop_ready;
  tag_t             pop_tag;
  tag_t             query_tag;
  logic             query_hit;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  int   vectors;
  int   miscompares;
  tag_t sb[$];
  tag_t pat [3];

  enum_tag_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_tag   (push_tag),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_tag    (pop_tag),
    .query_tag  (query_tag),
    .query_hit  (query_hit),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  function automatic logic model_hit(input tag_t q);
    foreach (sb[i]) if (sb[i] == q) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive, check pre-edge outputs at negedge, update model, advance.
  task automatic cyc(input logic pv, input tag_t pt, input logic pr, input logic fl, input tag_t qt);
    int unsigned pre;
    tag_t exp_head;
    push_valid = pv;
    push_tag   = pt;
    pop_ready  = pr;
    flush      = fl;
    query_tag  = qt;
    @(negedge clk);
    pre      = sb.size();
    exp_head = (pre != 0) ? sb[0] : TAG_0;
    check("count",      32'(count),      32'(pre));
    check("empty",      32'(empty),      32'(pre == 0));
    check("full",       32'(full),       32'(pre == DEPTH));
    check("push_ready", 32'(push_ready), 32'(pre != DEPTH));
    check("pop_valid",  32'(pop_valid),  32'(pre != 0));
    check("pop_tag",    32'(pop_tag),    32'(exp_head));
    check("query_hit",  32'(query_hit),  32'(model_hit(qt)));
    if (fl) sb.delete();
    else begin
      if (pr && pre != 0) void'(sb.pop_front());
      if (pv && pre != DEPTH) sb.push_back(pt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pat[0] = TAG_0; pat[1] = TAG_1; pat[2] = TAG_3;
    rst_n = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_tag = TAG_0; query_tag = TAG_0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset, query every tag.
    for (int i = 0; i < 4; i++) cyc(1'b0, TAG_0, 1'b0, 1'b0, tag_t'(i));

    // Ordered push/pop with queries.
    cyc(1'b1, TAG_0, 1'b0, 1'b0, TAG_0);
    cyc(1'b1, TAG_1, 1'b0, 1'b0, TAG_0);
    cyc(1'b1, TAG_3, 1'b0, 1'b0, TAG_1);
    cyc(1'b0, TAG_0, 1'b1, 1'b0, TAG_2);
    cyc(1'b0, TAG_0, 1'b1, 1'b0, TAG_1);
    cyc(1'b0, TAG_0, 1'b1, 1'b0, TAG_3);
    cyc(1'b0, TAG_0, 1'b0, 1'b0, TAG_3);

    // Fill, overflow push of TAG_2, drain; repeated for pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) cyc(1'b1, pat[(i + r) % 3], 1'b0, 1'b0, pat[i % 3]);
      cyc(1'b1, TAG_2, 1'b0, 1'b0, TAG_2);
      for (int i = 0; i < 5; i++) cyc(1'b0, TAG_0, 1'b1, 1'b0, TAG_2);
      cyc(1'b0, TAG_0, 1'b0, 1'b0, TAG_0);
    end

    // Simultaneous push/pop at two entries; query the head being popped.
    cyc(1'b1, TAG_1, 1'b0, 1'b0, TAG_0);
    cyc(1'b1, TAG_2, 1'b0, 1'b0, TAG_0);
    for (int i = 0; i < 10; i++) cyc(1'b1, tag_t'(i % 4), 1'b1, 1'b0, sb[0]);
    cyc(1'b0, TAG_0, 1'b1, 1'b0, TAG_1);
    cyc(1'b0, TAG_0, 1'b1, 1'b0, TAG_1);
    cyc(1'b0, TAG_0, 1'b0, 1'b0, TAG_2);

    // Flush beats a same-cycle push.
    cyc(1'b1, TAG_0, 1'b0, 1'b0, TAG_0);
    cyc(1'b1, TAG_1, 1'b0, 1'b0, TAG_0);
    cyc(1'b1, TAG_3, 1'b0, 1'b0, TAG_0);
    cyc(1'b1, TAG_2, 1'b1, 1'b1, TAG_0);
    cyc(1'b0, TAG_0, 1'b0, 1'b0, TAG_2);
    cyc(1'b0, TAG_0, 1'b0, 1'b0, TAG_0);

    // Asynchronous reset between edges while holding four entries.
    for (int i = 0; i < 4; i++) cyc(1'b1, pat[i % 3], 1'b0, 1'b0, TAG_0);
    push_valid = 1'b0;
    query_tag  = TAG_1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_count",      32'(count),      32'd0);
    check("rst_empty",      32'(empty),      32'd1);
    check("rst_full",       32'(full),       32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd1);
    check("rst_pop_valid",  32'(pop_valid),  32'd0);
    check("rst_pop_tag",    32'(pop_tag),    32'(TAG_0));
    check("rst_query_hit",  32'(query_hit),  32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, TAG_0, 1'b1, 1'b0, TAG_0);
    cyc(1'b0, TAG_0, 1'b0, 1'b0, TAG_1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
